// File: rtl/sr_latch_reader.sv
// ============================================================================
// Module  : sr_latch_reader
// Brief   : Synchronises and debounces the q / q_not rails of an async SR
//           latch. Outputs are a clean level, rise/fall pulses and a sticky
//           fault flag. Defining SR_LATCH_READER_FAULT_COUNT_EN adds a
//           saturating fault_count output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sr_latch_reader #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int FAULT_CNT_W   = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic q,
  input  logic q_not,
  input  logic clear_fault,
  output logic level,
  output logic rise,
  output logic fall,
  output logic fault
`ifdef SR_LATCH_READER_FAULT_COUNT_EN
  ,
  output logic [FAULT_CNT_W-1:0] fault_count
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    CLS_LOW  = 2'd0,
    CLS_HIGH = 2'd1,
    CLS_INV  = 2'd2
  } cls_t;

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_PEND   = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_q_sync;
  logic [SYNC_STAGES-1:0] r_qn_sync;
  state_t                 r_state;
  cls_t                   r_committed;
  cls_t                   r_target;
  logic [CNT_W-1:0]       r_cnt;
  cls_t                   w_sample;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_commit;

  // Chains reset to the LOW pair so release never looks like an invalid input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_sync  <= '0;
      r_qn_sync <= '1;
    end else begin
      r_q_sync  <= {r_q_sync[SYNC_STAGES-2:0], q};
      r_qn_sync <= {r_qn_sync[SYNC_STAGES-2:0], q_not};
    end
  end

  always_comb begin
    w_sample = CLS_INV;
    case ({r_q_sync[SYNC_STAGES-1], r_qn_sync[SYNC_STAGES-1]})
      2'b10:   w_sample = CLS_HIGH;
      2'b01:   w_sample = CLS_LOW;
      default: w_sample = CLS_INV;
    endcase
  end

  // A commit always carries the current sample: in PEND it only fires when
  // the sample equals the target.
  always_comb begin
    w_cnt_inc = r_cnt + 1'b1;
    w_commit  = 1'b0;
    case (r_state)
      ST_PEND: w_commit = (w_sample == r_target) && (w_cnt_inc == CNT_LAST);
      default: w_commit = (w_sample != r_committed) && (STABLE_CYCLES == 1);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_STABLE;
      r_committed <= CLS_LOW;
      r_target    <= CLS_LOW;
      r_cnt       <= '0;
      level       <= 1'b0;
      rise        <= 1'b0;
      fall        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (clear_fault) begin
        fault <= 1'b0;
      end
      if (w_commit) begin
        r_committed <= w_sample;
        r_cnt       <= '0;
        if (w_sample == CLS_INV) begin
          fault   <= 1'b1;
          r_state <= ST_FAULT;
        end else begin
          level   <= (w_sample == CLS_HIGH);
          rise    <= (w_sample == CLS_HIGH) && !level;
          fall    <= (w_sample == CLS_LOW) && level;
          r_state <= ST_STABLE;
        end
      end else begin
        case (r_state)
          ST_PEND: begin
            if (w_sample == r_target) begin
              r_cnt <= w_cnt_inc;
            end else if (w_sample == r_committed) begin
              r_state <= (r_committed == CLS_INV) ? ST_FAULT : ST_STABLE;
              r_cnt   <= '0;
            end else begin
              r_target <= w_sample;
              r_cnt    <= CNT_ONE;
            end
          end
          default: begin
            if (w_sample != r_committed) begin
              r_target <= w_sample;
              r_cnt    <= CNT_ONE;
              r_state  <= ST_PEND;
            end
          end
        endcase
      end
    end
  end

`ifdef SR_LATCH_READER_FAULT_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_count <= '0;
    end else if (w_commit && (w_sample == CLS_INV) && (fault_count != '1)) begin
      fault_count <= fault_count + 1'b1;
    end
  end
`else
  // FAULT_CNT_W only sizes the optional counter.
  if (FAULT_CNT_W < 1) begin : g_no_fault_count
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_reader.sv
// ============================================================================
// Module  : tb_sr_latch_reader
// Brief   : Self-checking bench for sr_latch_reader (vector table, directed
//           sequences, randomized stimulus against a run-length model).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sr_latch_reader;

  localparam int SS = 2;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset_n, q, q_not, clear_fault;
  logic level, rise, fall, fault;
`ifdef SR_LATCH_READER_FAULT_COUNT_EN
  logic [1:0] fault_count;
`endif

  int checks   = 0;
  int failures = 0;

  sr_latch_reader #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .FAULT_CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .q(q), .q_not(q_not), .clear_fault(clear_fault),
    .level(level), .rise(rise), .fall(fall), .fault(fault)
`ifdef SR_LATCH_READER_FAULT_COUNT_EN
    , .fault_count(fault_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: delay line of input pairs plus run length of identical classes.
  logic [1:0] pipe[$];
  int m_committed, m_run_cls, m_run_len, m_count;
  bit m_level, m_rise, m_fall, m_fault;

  function automatic int cls_of(input logic [1:0] p);
    if (p == 2'b10) return 1;
    if (p == 2'b01) return 0;
    return 2;
  endfunction

  task automatic model_reset();
    pipe = {};
    repeat (SS) pipe.push_back(2'b01);
    m_committed = 0; m_run_cls = 0; m_run_len = SC;
    m_level = 0; m_rise = 0; m_fall = 0; m_fault = 0; m_count = 0;
  endtask

  task automatic model_step(input logic a, input logic b, input logic c);
    logic [1:0] seen;
    int cls;
    if (!reset_n) begin
      model_reset();
      return;
    end
    seen = pipe.pop_front();
    pipe.push_back({a, b});
    cls = cls_of(seen);
    if (cls == m_run_cls) begin
      if (m_run_len < SC) m_run_len++;
    end else begin
      m_run_cls = cls;
      m_run_len = 1;
    end
    m_rise = 0;
    m_fall = 0;
    if (c) m_fault = 0;
    if (m_run_cls != m_committed && m_run_len == SC) begin
      m_committed = m_run_cls;
      if (cls == 2) begin
        m_fault = 1;
        if (m_count < 3) m_count++;
      end else begin
        m_rise  = (cls == 1) && !m_level;
        m_fall  = (cls == 0) && m_level;
        m_level = (cls == 1);
      end
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got {level,rise,fall,fault}=%b want %b", name, $time, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check(name, {level, rise, fall, fault}, {m_level, m_rise, m_fall, m_fault});
    checks++;
    if (rise && fall) begin
      failures++;
      $display("FAIL %s_excl @%0t: rise and fall both high", name, $time);
    end
`ifdef SR_LATCH_READER_FAULT_COUNT_EN
    checks++;
    if (fault_count !== 2'(m_count)) begin
      failures++;
      $display("FAIL %s_count @%0t: got %0d want %0d", name, $time, fault_count, m_count);
    end
`endif
  endtask

  task automatic tick(input logic a, input logic b, input logic c);
    q = a; q_not = b; clear_fault = c;
    @(posedge clk);
    #1;
    model_step(a, b, c);
  endtask

  typedef struct {
    logic       q, qn, clr;
    logic [3:0] exp;  // {level, rise, fall, fault}
  } vec_t;

  vec_t vecs[$];

  task automatic put(input int n, input logic a, input logic b, input logic c, input logic [3:0] e);
    for (int i = 0; i < n; i++) vecs.push_back('{a, b, c, e});
  endtask

  initial begin
    reset_n = 1'b0; q = 1'b1; q_not = 1'b0; clear_fault = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {level, rise, fall, fault}, 4'b0000);
    reset_n = 1'b1;

    put(5, 1, 0, 0, 4'b0000); put(1, 1, 0, 0, 4'b1100); put(1, 1, 0, 0, 4'b1000);  // commit HIGH
    put(3, 0, 1, 0, 4'b1000); put(5, 1, 0, 0, 4'b1000);                            // glitch rejected
    put(5, 0, 1, 0, 4'b1000); put(1, 0, 1, 0, 4'b0010); put(1, 0, 1, 0, 4'b0000);  // commit LOW
    put(5, 1, 1, 0, 4'b0000); put(1, 1, 1, 0, 4'b0001);                            // invalid 11
    put(2, 0, 0, 0, 4'b0001);                                                      // 00 same class
    put(5, 1, 0, 0, 4'b0001); put(1, 1, 0, 0, 4'b1101);                            // leave fault
    put(1, 1, 0, 1, 4'b1000); put(1, 1, 0, 0, 4'b1000);                            // clear_fault
    put(5, 0, 0, 0, 4'b1000); put(1, 0, 0, 1, 4'b1001); put(1, 0, 0, 0, 4'b1001);  // set wins
    put(5, 0, 1, 0, 4'b1001); put(1, 0, 1, 0, 4'b0011);                            // fall from fault
    put(6, 1, 1, 0, 4'b0001); put(6, 0, 1, 0, 4'b0001);                            // same level, no pulse
    foreach (vecs[i]) begin
      tick(vecs[i].q, vecs[i].qn, vecs[i].clr);
      check($sformatf("vec%0d", i), {level, rise, fall, fault}, vecs[i].exp);
      check_model($sformatf("vec%0d_model", i));
    end

    // Reset while three samples toward HIGH are pending.
    repeat (5) tick(1, 0, 0);
    reset_n = 1'b0; q = 1'b0; q_not = 1'b1;
    model_reset();
    #1;
    check("midpend_reset", {level, rise, fall, fault}, 4'b0000);
    tick(0, 1, 0);
    tick(0, 1, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 0);
      check($sformatf("midpend_after%0d", i), {level, rise, fall, fault}, 4'b0000);
    end

`ifdef SR_LATCH_READER_FAULT_COUNT_EN
    reset_n = 1'b0; model_reset(); #1; reset_n = 1'b1;
    for (int e = 0; e < 5; e++) begin
      repeat (6) tick(1, 1, 0);
      checks++;
      if (fault_count !== 2'((e < 3) ? e + 1 : 3)) begin
        failures++;
        $display("FAIL fault_count_ep%0d: got %0d want %0d", e, fault_count, (e < 3) ? e + 1 : 3);
      end
      repeat (6) tick(0, 1, 1);
    end
`endif

    for (int s = 0; s < 60; s++) begin
      logic [1:0] pr;
      int len;
      pr  = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        tick(pr[1], pr[0], ($urandom_range(0, 7) == 0));
        check_model("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
